hub_sys_n: RTL and testbench
============================

HUB_SYS_N -- requirements
Module: hub_sys_n

Interface
REQ-001 Parameter NCOG, default 8, cog count; legal values 2, 4, 8, 16.
REQ-002 Parameter NLOCK, default 8, lock count; legal values 2, 4, 8, 16, 32.
REQ-003 Derived widths: CW=log2(NCOG), LW=log2(NLOCK), QW=max(CW,LW).
REQ-004 Clock and reset: one clock, clk_cog; reset nres is asynchronous, active-low.
REQ-005 clk_cog  in  1  system clock.
REQ-006 nres  in  1  asynchronous active-low reset.
REQ-007 ena_bus  in  1  hub slot enable; all state advances only on clk_cog edges with ena_bus=1, except ack and ptr_w clearing.
REQ-008 bus_e  in  1  sys request from the cog owning the current slot.
REQ-009 bus_op  in  3  op code: 000 CLKSET, 001 COGID, 010 COGINIT, 011 COGSTOP, 100 LOCKNEW, 101 LOCKRET, 110 LOCKSET, 111 LOCKCLR.
REQ-010 bus_d  in  32  op data: id in [CW-1:0] or [LW-1:0], new-flag [4], ptr [31:5], config [7:0].
REQ-011 slot  out  CW  index of the cog owning the current hub slot.
REQ-012 ack  out  NCOG  one-hot completion strobe to the requester.
REQ-013 sys_q  out  QW  op result.
REQ-014 sys_c  out  1  op carry result.
REQ-015 cog_ena  out  NCOG  per-cog run enable.
REQ-016 ptr_w  out  NCOG  one-hot strobe that loads ptr_d into the started cog.
REQ-017 ptr_d  out  27  start pointer, registered copy of bus_d[31:5].
REQ-018 cfg  out  8  clock configuration.

Function
REQ-019 slot increments on every ena_bus edge; it wraps from NCOG-1 to 0.
REQ-020 The requester is the slot value at the executing edge; an op executes on an edge with ena_bus=1 and bus_e=1; at most one op executes per edge.
REQ-021 At the executing edge: state updates; sys_q and sys_c are registered; ack is set to 1<<requester.
REQ-022 ack and ptr_w are high for exactly one clk_cog cycle after the executing edge, then 0.
REQ-023 newx is the lowest index of a clear bit in the target map (cog_e for COGINIT, lock_e for LOCKNEW); all=1 when every bit is set.
REQ-024 CLKSET: cfg<=bus_d[7:0]; sys_q=0; sys_c=all(cog_e).
REQ-025 COGID: sys_q=requester; no state change.
REQ-026 COGINIT, new-flag=1, all=0: target=newx; cog_e[target]<=1; sys_q=target; sys_c=0.
REQ-027 COGINIT, new-flag=1, all=1: no state change; sys_q=NCOG-1; sys_c=1; ptr_w stays 0.
REQ-028 COGINIT, new-flag=0: target=bus_d[CW-1:0], whether running or not, including the requester itself; target is restarted.
REQ-029 Any COGINIT start: ptr_w pulses for target; ptr_d loads; cog_ena[target] is 0 for the ena_bus period following the edge, then 1.
REQ-030 COGSTOP: cog_e[id]<=0; every lock whose owner is id has lock_e and lock_state cleared in the same edge; sys_q=id.
REQ-031 LOCKNEW: if all=0, lock_e[newx]<=1, lock_state[newx]<=0, owner[newx]<=requester, sys_q=newx, sys_c=0; if all=1, no change, sys_c=1.
REQ-032 LOCKRET: lock_e[id]<=0; sys_q=id; ownership is not checked.
REQ-033 LOCKSET/LOCKCLR: sys_c=prior lock_state[id]; lock_state[id]<=1 for LOCKSET, 0 for LOCKCLR; sys_q=id; legal on unallocated locks.
REQ-034 Ids are truncated to CW or LW bits; sys_q is zero-extended to QW.
REQ-035 cog_ena is registered from cog_e and masked by any start pulse.

Reset
REQ-036 Asserting nres forces the following values, including mid-operation: slot=0, cog_e=1 (cog 0 only), cog_ena=0, lock_e=0, lock_state=0, owners=0, cfg=0, ack=0, ptr_w=0, ptr_d=0, sys_q=0, sys_c=0.
REQ-037 After release, cog_ena=1 (cog 0) from the first ena_bus edge onward.
REQ-038 An op pending at reset is discarded; no ack is issued.

Verification
REQ-039 NCOG=8, reset, slot 3, COGINIT new=1, d[31:5]=0x100 -> sys_q=1, sys_c=0, ptr_w=0x02, ptr_d=0x100, ack=0x08.
REQ-040 Start all 8 cogs, then COGINIT new=1 -> sys_c=1, sys_q=7, ptr_w=0, cog_e unchanged.
REQ-041 NLOCK=16, cog 2 LOCKNEW x3 -> sys_q=0,1,2; COGSTOP 2 from cog 0 -> lock_e=0, and the next LOCKNEW returns sys_q=0.
REQ-042 LOCKSET 5 twice, then LOCKCLR 5 -> sys_c=0, 1, 1; final lock_state[5]=0.
REQ-043 Cog 4 COGINIT id=4 new=0 -> cog_ena[4]=0 for one ena_bus period, then 1; ptr_w=0x10.
REQ-044 nres asserted in the cycle between the executing edge and the ack -> ack=0, cfg=0, cog_e=0x01, slot=0.

Source files
------------

// File: rtl/hub_sys_n.sv
// hub_sys_n: hub "sys" op executor.
// A rotating slot pointer selects the cog allowed to issue a sys op.
// The block keeps cog run enables, the lock pool (alloc map, state, owner)
// and the clock config. It returns a result, a carry and a one-hot ack to
// the requester.
module hub_sys_n #(
    parameter int NCOG  = 8,
    parameter int NLOCK = 8,
    localparam int CW = $clog2(NCOG),
    localparam int LW = $clog2(NLOCK),
    localparam int QW = (CW > LW) ? CW : LW
) (
    input  logic            clk_cog,
    input  logic            nres,
    input  logic            ena_bus,
    input  logic            bus_e,
    input  logic [2:0]      bus_op,
    input  logic [31:0]     bus_d,
    output logic [CW-1:0]   slot,
    output logic [NCOG-1:0] ack,
    output logic [QW-1:0]   sys_q,
    output logic            sys_c,
    output logic [NCOG-1:0] cog_ena,
    output logic [NCOG-1:0] ptr_w,
    output logic [26:0]     ptr_d,
    output logic [7:0]      cfg
);

    localparam logic [2:0] OP_CLKSET  = 3'd0;
    localparam logic [2:0] OP_COGID   = 3'd1;
    localparam logic [2:0] OP_COGINIT = 3'd2;
    localparam logic [2:0] OP_COGSTOP = 3'd3;
    localparam logic [2:0] OP_LOCKNEW = 3'd4;
    localparam logic [2:0] OP_LOCKRET = 3'd5;
    localparam logic [2:0] OP_LOCKSET = 3'd6;
    localparam logic [2:0] OP_LOCKCLR = 3'd7;

    // Lowest index of a clear bit in the cog map (0 when the map is full).
    function automatic logic [CW-1:0] cog_first_clear(input logic [NCOG-1:0] map);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCOG - 1; i >= 0; i--) begin
            if (!map[i]) begin
                idx = CW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Lowest index of a clear bit in the lock map (0 when the map is full).
    function automatic logic [LW-1:0] lock_first_clear(input logic [NLOCK-1:0] map);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = NLOCK - 1; i >= 0; i--) begin
            if (!map[i]) begin
                idx = LW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // State registers
    logic [CW-1:0]              slot_q,       slot_d;
    logic [NCOG-1:0]            cog_e_q,      cog_e_d;
    logic [NCOG-1:0]            cog_ena_q,    cog_ena_d;
    logic [NLOCK-1:0]           lock_e_q,     lock_e_d;
    logic [NLOCK-1:0]           lock_state_q, lock_state_d;
    logic [NLOCK-1:0][CW-1:0]   owner_q,      owner_d;
    logic [7:0]                 cfg_q,        cfg_d;
    logic [NCOG-1:0]            ack_q,        ack_d;
    logic [NCOG-1:0]            ptr_w_q,      ptr_w_d;
    logic [26:0]                ptr_d_q,      ptr_d_d;
    logic [QW-1:0]              sys_q_q,      sys_q_d;
    logic                       sys_c_q,      sys_c_d;

    // Decoded request fields
    logic            exec_s;
    logic [CW-1:0]   req_s;
    logic [CW-1:0]   cog_id_s;
    logic [LW-1:0]   lock_id_s;
    logic            new_flag_s;
    logic [CW-1:0]   cog_newx_s;
    logic            cog_all_s;
    logic [LW-1:0]   lock_newx_s;
    logic            lock_all_s;
    logic [NCOG-1:0] start_s;
    logic [CW-1:0]   cog_tgt_s;

    assign exec_s      = ena_bus & bus_e;
    assign req_s       = slot_q;
    assign cog_id_s    = bus_d[CW-1:0];
    assign lock_id_s   = bus_d[LW-1:0];
    assign new_flag_s  = bus_d[4];
    assign cog_newx_s  = cog_first_clear(cog_e_q);
    assign cog_all_s   = &cog_e_q;
    assign lock_newx_s = lock_first_clear(lock_e_q);
    assign lock_all_s  = &lock_e_q;

    // Next-state: slot rotation, op execution and one-cycle strobes.
    always_comb begin
        slot_d       = ena_bus ? (slot_q + CW'(1)) : slot_q;
        cog_e_d      = cog_e_q;
        lock_e_d     = lock_e_q;
        lock_state_d = lock_state_q;
        owner_d      = owner_q;
        cfg_d        = cfg_q;
        ptr_d_d      = ptr_d_q;
        sys_q_d      = sys_q_q;
        sys_c_d      = sys_c_q;
        ack_d        = '0;
        start_s      = '0;
        cog_tgt_s    = new_flag_s ? cog_newx_s : cog_id_s;

        if (exec_s) begin
            ack_d[req_s] = 1'b1;
            case (bus_op)
                OP_CLKSET: begin
                    cfg_d   = bus_d[7:0];
                    sys_q_d = '0;
                    sys_c_d = cog_all_s;
                end
                OP_COGID: begin
                    sys_q_d = QW'(req_s);
                    sys_c_d = 1'b0;
                end
                OP_COGINIT: begin
                    if (new_flag_s && cog_all_s) begin
                        // No free cog: report failure, start nothing.
                        sys_q_d = QW'(NCOG - 1);
                        sys_c_d = 1'b1;
                    end else begin
                        cog_e_d[cog_tgt_s] = 1'b1;
                        start_s[cog_tgt_s] = 1'b1;
                        ptr_d_d            = bus_d[31:5];
                        sys_q_d            = QW'(cog_tgt_s);
                        sys_c_d            = 1'b0;
                    end
                end
                OP_COGSTOP: begin
                    cog_e_d[cog_id_s] = 1'b0;
                    // Locks owned by the stopped cog are released with it.
                    for (int i = 0; i < NLOCK; i++) begin
                        lock_e_d[i]     = (owner_q[i] == cog_id_s) ? 1'b0 : lock_e_q[i];
                        lock_state_d[i] = (owner_q[i] == cog_id_s) ? 1'b0 : lock_state_q[i];
                    end
                    sys_q_d = QW'(cog_id_s);
                    sys_c_d = 1'b0;
                end
                OP_LOCKNEW: begin
                    if (lock_all_s) begin
                        sys_q_d = QW'(NLOCK - 1);
                        sys_c_d = 1'b1;
                    end else begin
                        lock_e_d[lock_newx_s]     = 1'b1;
                        lock_state_d[lock_newx_s] = 1'b0;
                        owner_d[lock_newx_s]      = req_s;
                        sys_q_d                   = QW'(lock_newx_s);
                        sys_c_d                   = 1'b0;
                    end
                end
                OP_LOCKRET: begin
                    lock_e_d[lock_id_s] = 1'b0;
                    sys_q_d             = QW'(lock_id_s);
                    sys_c_d             = 1'b0;
                end
                OP_LOCKSET: begin
                    sys_c_d                 = lock_state_q[lock_id_s];
                    lock_state_d[lock_id_s] = 1'b1;
                    sys_q_d                 = QW'(lock_id_s);
                end
                OP_LOCKCLR: begin
                    sys_c_d                 = lock_state_q[lock_id_s];
                    lock_state_d[lock_id_s] = 1'b0;
                    sys_q_d                 = QW'(lock_id_s);
                end
                default: begin
                    sys_c_d = sys_c_q;
                end
            endcase
        end else begin
            ack_d = '0;
        end

        ptr_w_d = start_s;
        // A started cog is held off for one slot period, then runs.
        cog_ena_d = ena_bus ? (cog_e_d & ~start_s) : cog_ena_q;
    end

    // State update; reset leaves only cog 0 enabled.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot_q       <= '0;
            cog_e_q      <= {{(NCOG-1){1'b0}}, 1'b1};
            cog_ena_q    <= '0;
            lock_e_q     <= '0;
            lock_state_q <= '0;
            owner_q      <= '0;
            cfg_q        <= 8'h00;
            ack_q        <= '0;
            ptr_w_q      <= '0;
            ptr_d_q      <= 27'h0;
            sys_q_q      <= '0;
            sys_c_q      <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cog_e_q      <= cog_e_d;
            cog_ena_q    <= cog_ena_d;
            lock_e_q     <= lock_e_d;
            lock_state_q <= lock_state_d;
            owner_q      <= owner_d;
            cfg_q        <= cfg_d;
            ack_q        <= ack_d;
            ptr_w_q      <= ptr_w_d;
            ptr_d_q      <= ptr_d_d;
            sys_q_q      <= sys_q_d;
            sys_c_q      <= sys_c_d;
        end
    end

    assign slot    = slot_q;
    assign ack     = ack_q;
    assign sys_q   = sys_q_q;
    assign sys_c   = sys_c_q;
    assign cog_ena = cog_ena_q;
    assign ptr_w   = ptr_w_q;
    assign ptr_d   = ptr_d_q;
    assign cfg     = cfg_q;

endmodule

// File: tb/tb_hub_sys_n.sv
// Testbench for hub_sys_n (NCOG=8, NLOCK=16): op table driven through a
// scoreboard queue, plus hand sequences for restart hold-off and reset.
module tb_hub_sys_n;

    localparam logic [2:0] OP_CLKSET  = 3'd0;
    localparam logic [2:0] OP_COGID   = 3'd1;
    localparam logic [2:0] OP_COGINIT = 3'd2;
    localparam logic [2:0] OP_COGSTOP = 3'd3;
    localparam logic [2:0] OP_LOCKNEW = 3'd4;
    localparam logic [2:0] OP_LOCKRET = 3'd5;
    localparam logic [2:0] OP_LOCKSET = 3'd6;
    localparam logic [2:0] OP_LOCKCLR = 3'd7;

    logic        clk_cog;
    logic        nres;
    logic        ena_bus;
    logic        bus_e;
    logic [2:0]  bus_op;
    logic [31:0] bus_d;
    logic [2:0]  slot;
    logic [7:0]  ack;
    logic [3:0]  sys_q;
    logic        sys_c;
    logic [7:0]  cog_ena;
    logic [7:0]  ptr_w;
    logic [26:0] ptr_d;
    logic [7:0]  cfg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  op;
        logic [31:0] d;
        logic [3:0]  q;
        logic        c;
        logic        chk_q;
        logic        chk_c;
        logic [7:0]  pw;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    hub_sys_n #(.NCOG(8), .NLOCK(16)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena_bus (ena_bus),
        .bus_e   (bus_e),
        .bus_op  (bus_op),
        .bus_d   (bus_d),
        .slot    (slot),
        .ack     (ack),
        .sys_q   (sys_q),
        .sys_c   (sys_c),
        .cog_ena (cog_ena),
        .ptr_w   (ptr_w),
        .ptr_d   (ptr_d),
        .cfg     (cfg)
    );

    initial begin
        clk_cog = 1'b0;
        forever #5 clk_cog = ~clk_cog;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic [2:0] req, input logic [2:0] op, input logic [31:0] d,
                               input logic [3:0] q, input logic c, input logic chk_q,
                               input logic chk_c, input logic [7:0] pw);
        vec_t r;
        r.req = req; r.op = op; r.d = d; r.q = q; r.c = c;
        r.chk_q = chk_q; r.chk_c = chk_c; r.pw = pw;
        return r;
    endfunction

    function automatic logic [31:0] dd(input logic [26:0] ptr, input logic nf, input logic [3:0] id);
        return {ptr, nf, id};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for the requester's slot, issue one op, compare result and strobes.
    task automatic run_op(input vec_t t, input bit hold_ena);
        int   n;
        vec_t e;
        logic [7:0] exp_ack;
        n = 0;
        @(negedge clk_cog);
        while (slot !== t.req && n < 32) begin
            @(negedge clk_cog);
            n++;
        end
        chk("slot_wait", 32'(slot), 32'(t.req));
        if (slot !== t.req) return;
        bus_e  = 1'b1;
        bus_op = t.op;
        bus_d  = t.d;
        sb.push_back(t);
        @(posedge clk_cog); #1;
        bus_e = 1'b0;
        if (hold_ena) ena_bus = 1'b0;
        e = sb.pop_front();
        exp_ack = 8'h01 << e.req;
        chk("ack", 32'(ack), 32'(exp_ack));
        if (e.chk_q) chk("sys_q", 32'(sys_q), 32'(e.q));
        if (e.chk_c) chk("sys_c", 32'(sys_c), 32'(e.c));
        chk("ptr_w", 32'(ptr_w), 32'(e.pw));
        if (e.pw != 8'h00) chk("ptr_d", 32'(ptr_d), 32'(e.d[31:5]));
        @(posedge clk_cog); #1;
        chk("ack_clear", 32'(ack), 32'h0);
        chk("ptr_w_clear", 32'(ptr_w), 32'h0);
    endtask

    initial begin
        nres    = 1'b0;
        ena_bus = 1'b1;
        bus_e   = 1'b0;
        bus_op  = 3'd0;
        bus_d   = 32'h0;

        // Op table, executed in order from reset.
        tbl.push_back(v(3'd3, OP_COGINIT, dd(27'h100, 1'b1, 4'd0), 4'd1, 1'b0, 1'b1, 1'b1, 8'h02));
        tbl.push_back(v(3'd5, OP_COGID,   32'h0,                   4'd5, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(3'd1, OP_CLKSET,  32'h0000_00A5,           4'd0, 1'b0, 1'b1, 1'b1, 8'h00));
        for (int i = 2; i < 8; i++) begin
            tbl.push_back(v(3'd0, OP_COGINIT, dd(27'h200 + 27'(i), 1'b1, 4'd0), 4'(i), 1'b0,
                            1'b1, 1'b1, 8'h01 << i));
        end
        tbl.push_back(v(3'd2, OP_COGINIT, dd(27'h3FF, 1'b1, 4'd0), 4'd7, 1'b1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd1, OP_CLKSET,  32'h0000_003C,           4'd0, 1'b1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd2, OP_LOCKNEW, 32'h0,                   4'd0, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd2, OP_LOCKNEW, 32'h0,                   4'd1, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd2, OP_LOCKNEW, 32'h0,                   4'd2, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd0, OP_COGSTOP, dd(27'h0, 1'b0, 4'd2),   4'd2, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(3'd3, OP_LOCKNEW, 32'h0,                   4'd0, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd3, OP_LOCKSET, dd(27'h0, 1'b0, 4'd5),   4'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd4, OP_LOCKSET, dd(27'h0, 1'b0, 4'd5),   4'd5, 1'b1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd6, OP_LOCKCLR, dd(27'h0, 1'b0, 4'd5),   4'd5, 1'b1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd6, OP_LOCKSET, dd(27'h0, 1'b0, 4'd5),   4'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd4, OP_COGINIT, dd(27'h0AB, 1'b0, 4'd4), 4'd4, 1'b0, 1'b0, 1'b0, 8'h10));
        tbl.push_back(v(3'd7, OP_COGINIT, dd(27'h0CD, 1'b1, 4'd0), 4'd2, 1'b0, 1'b1, 1'b1, 8'h04));
        tbl.push_back(v(3'd0, OP_LOCKRET, dd(27'h0, 1'b0, 4'd0),   4'd0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(3'd1, OP_LOCKNEW, 32'h0,                   4'd0, 1'b0, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(3'd0, OP_LOCKSET, 32'h0000_0025,           4'd5, 1'b1, 1'b1, 1'b1, 8'h00));

        // Reset state
        #1;
        chk("rst_slot",    32'(slot),    32'h0);
        chk("rst_ack",     32'(ack),     32'h0);
        chk("rst_cog_ena", 32'(cog_ena), 32'h0);
        chk("rst_ptr_w",   32'(ptr_w),   32'h0);
        chk("rst_ptr_d",   32'(ptr_d),   32'h0);
        chk("rst_cfg",     32'(cfg),     32'h0);
        chk("rst_sys_q",   32'(sys_q),   32'h0);
        chk("rst_sys_c",   32'(sys_c),   32'h0);
        repeat (2) @(posedge clk_cog);
        @(negedge clk_cog);
        nres = 1'b1;
        @(posedge clk_cog); #1;
        chk("first_edge_cog_ena", 32'(cog_ena), 32'h01);
        chk("first_edge_slot",    32'(slot),    32'h1);

        foreach (tbl[k]) run_op(tbl[k], 1'b0);
        chk("cfg_after_table",     32'(cfg),     32'h3C);
        chk("cog_ena_after_table", 32'(cog_ena), 32'hFF);

        // Self-restart of cog 4 with ena_bus held low: hold-off lasts the whole period.
        run_op(v(3'd4, OP_COGINIT, dd(27'h055, 1'b0, 4'd4), 4'd4, 1'b0, 1'b1, 1'b1, 8'h10), 1'b1);
        chk("restart_hold_ena", 32'(cog_ena), 32'hEF);
        chk("restart_hold_slot", 32'(slot), 32'h5);
        @(posedge clk_cog); #1;
        chk("restart_hold_ena2", 32'(cog_ena), 32'hEF);
        ena_bus = 1'b1;
        @(posedge clk_cog); #1;
        chk("restart_run_ena", 32'(cog_ena), 32'hFF);
        chk("restart_run_slot", 32'(slot), 32'h6);

        // Reset asserted right after an executing CLKSET.
        @(negedge clk_cog);
        while (slot !== 3'd1) @(negedge clk_cog);
        bus_e  = 1'b1;
        bus_op = OP_CLKSET;
        bus_d  = 32'h0000_0077;
        @(posedge clk_cog); #1;
        chk("pre_reset_cfg", 32'(cfg), 32'h77);
        #1 nres = 1'b0;
        #1;
        chk("mid_rst_ack",     32'(ack),     32'h0);
        chk("mid_rst_cfg",     32'(cfg),     32'h0);
        chk("mid_rst_slot",    32'(slot),    32'h0);
        chk("mid_rst_cog_ena", 32'(cog_ena), 32'h0);
        chk("mid_rst_sys_c",   32'(sys_c),   32'h0);
        chk("mid_rst_ptr_d",   32'(ptr_d),   32'h0);
        // Request held through reset edges is discarded.
        repeat (2) @(posedge clk_cog);
        #1;
        chk("rst_pending_ack", 32'(ack), 32'h0);
        bus_e = 1'b0;
        @(negedge clk_cog);
        nres = 1'b1;
        @(posedge clk_cog); #1;
        chk("post_rst_cog_ena", 32'(cog_ena), 32'h01);
        chk("post_rst_slot",    32'(slot),    32'h1);
        run_op(v(3'd3, OP_COGINIT, dd(27'h100, 1'b1, 4'd0), 4'd1, 1'b0, 1'b1, 1'b1, 8'h02), 1'b0);
        run_op(v(3'd2, OP_LOCKNEW, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 8'h00), 1'b0);
        run_op(v(3'd1, OP_CLKSET,  32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 8'h00), 1'b0);
        chk("post_rst_cfg", 32'(cfg), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
